// File: rtl/sme_bank_xfer_if.sv
// sme_bank_xfer_if: load/store request, memory and bank-port bundle.
// slave = sequencer view, master = core/memory/bank view.
interface sme_bank_xfer_if #(
  parameter int XLEN = 32
);
  logic            ld_valid;
  logic            ld_ready;
  logic [3:0]      ld_rd_addr;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_rdata;
  logic            st_valid;
  logic            st_ready;
  logic            mem_st_valid;
  logic            mem_st_ready;
  logic [XLEN-1:0] mem_st_wdata;
  logic            bank_wen;
  logic [3:0]      bank_waddr;
  logic [XLEN-1:0] bank_wdata;
  logic            bank_read;
  logic [XLEN-1:0] bank_rdata;

  modport slave (
    input  ld_valid, ld_rd_addr, rsp_valid, rsp_rdata,
    input  st_valid, mem_st_ready, bank_rdata,
    output ld_ready, st_ready, mem_st_valid, mem_st_wdata,
    output bank_wen, bank_waddr, bank_wdata, bank_read
  );

  modport master (
    output ld_valid, ld_rd_addr, rsp_valid, rsp_rdata,
    output st_valid, mem_st_ready, bank_rdata,
    input  ld_ready, st_ready, mem_st_valid, mem_st_wdata,
    input  bank_wen, bank_waddr, bank_wdata, bank_read
  );
endinterface

// File: rtl/sme_bank_xfer.sv
// sme_bank_xfer: SME share-bank load/store sequencer.
// Option SME_XFER_ZEROISE_EN: scrub share data from registers.
module sme_bank_xfer #(
  parameter int XLEN  = 32,
  parameter int SMAX  = 4,
  parameter int DEPTH = 4
) (
  input  logic            g_clk,
  input  logic            g_resetn,
  output logic            g_clk_req,
  input  logic            flush,
  input  logic [XLEN-1:0] csr_smectl,
  output logic            err_underflow,
  sme_bank_xfer_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_HOLD
  } st_e;

  logic [3:0]      addr_q [DEPTH];
  logic [DEPTH-1:0] kill_q;
  logic [AW-1:0]   rd_q, wr_q;
  logic [AW:0]     count_q, count_d;
  logic            full, empty, push, pop;
  logic            bsel_ok, wen_d;
  logic            wen_q, err_q;
  logic [3:0]      waddr_q;
  logic [XLEN-1:0] wdata_q;
  st_e             state_q, state_d;
  logic [XLEN-1:0] sdata_q;
  logic            st_rdy, st_rd, st_vld;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign pop     = bus.rsp_valid && !empty;
  assign bus.ld_ready = g_resetn && !flush &&
                        (!full || bus.rsp_valid);
  assign push    = bus.ld_valid && bus.ld_ready;
  assign count_d = count_q + {{AW{1'b0}}, push}
                           - {{AW{1'b0}}, pop};
  assign bsel_ok = (csr_smectl[3:0] != 4'd0) &&
                   ({1'b0, csr_smectl[3:0]} < 5'(SMAX));
  assign wen_d   = pop && !kill_q[rd_q] && !flush && bsel_ok;

  // Load tag FIFO, registered bank write and sticky underflow
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
      kill_q  <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (flush) kill_q <= '1;
      if (pop) begin
        rd_q    <= rd_q + 1'b1;
        waddr_q <= addr_q[rd_q];
`ifdef SME_XFER_ZEROISE_EN
        addr_q[rd_q] <= '0;
`endif
      end
      if (push) begin
        addr_q[wr_q] <= bus.ld_rd_addr;
        kill_q[wr_q] <= 1'b0;
        wr_q         <= wr_q + 1'b1;
      end
      wen_q <= wen_d;
`ifdef SME_XFER_ZEROISE_EN
      wdata_q <= wen_d ? bus.rsp_rdata : '0;
`else
      if (pop) wdata_q <= bus.rsp_rdata;
`endif
      if (bus.rsp_valid && empty) err_q <= 1'b1;
    end
  end

  // Store FSM state register
  always_ff @(posedge g_clk) begin
    if (!g_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Store FSM next state and strobes
  always_comb begin
    state_d = state_q;
    st_rdy  = 1'b0;
    st_rd   = 1'b0;
    st_vld  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        st_rdy = g_resetn && !flush;
        if (bus.st_valid && st_rdy) state_d = ST_READ;
      end
      ST_READ: begin
        st_rd   = 1'b1;
        state_d = flush ? ST_IDLE : ST_HOLD;
      end
      ST_HOLD: begin
        st_vld = 1'b1;
        if (bus.mem_st_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Store data capture from the bank read port
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      sdata_q <= '0;
    end else if (state_q == ST_READ && !flush) begin
      sdata_q <= bus.bank_rdata;
`ifdef SME_XFER_ZEROISE_EN
    end else if (state_q == ST_READ) begin
      sdata_q <= '0;
    end else if (state_q == ST_HOLD && bus.mem_st_ready) begin
      sdata_q <= '0;
`endif
    end
  end

  assign bus.st_ready     = st_rdy;
  assign bus.bank_read    = st_rd;
  assign bus.mem_st_valid = st_vld;
  assign bus.mem_st_wdata = sdata_q;
  assign bus.bank_wen     = wen_q;
  assign bus.bank_waddr   = waddr_q;
  assign bus.bank_wdata   = wdata_q;
  assign err_underflow    = err_q;
  assign g_clk_req = g_resetn &&
                     (!empty || state_q != ST_IDLE ||
                      bus.ld_valid || bus.st_valid);
endmodule
